icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 136 +++++++++++++
 tb/tb_icache.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, single outstanding fill.
// All outputs are registered; rdy_in low freezes every register including the arrays.
module icache #(
   parameter int INDEX_BITS = 6,
   parameter int ADDR_W     = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              fetch_able,
   input  logic [ADDR_W-1:0] fetch_pc,
   input  logic              flush,
   output logic [31:0]       ins_out,
   output logic              ins_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_data,
   input  logic              mem_done
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_W - 2 - INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MISS  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES];

   logic [INDEX_BITS-1:0] pc_idx, fill_idx;
   logic [TAG_W-1:0]      pc_tag, fill_tag;
   logic                  hit;

   logic              ready_d;
   logic [31:0]       out_d;
   logic              req_d;
   logic [ADDR_W-1:0] addr_d;
   logic              fill_we;

   // Byte-offset bits never take part in lookup or fill.
   logic unused_offset;
   assign unused_offset = ^{fetch_pc[1:0], mem_addr[1:0]};

   assign pc_idx   = fetch_pc[2+INDEX_BITS-1:2];
   assign pc_tag   = fetch_pc[ADDR_W-1:2+INDEX_BITS];
   // The fill target comes from the latched request, not the live pc.
   assign fill_idx = mem_addr[2+INDEX_BITS-1:2];
   assign fill_tag = mem_addr[ADDR_W-1:2+INDEX_BITS];
   assign hit      = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

   // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      ready_d = 1'b0;
      out_d   = ins_out;
      req_d   = mem_req;
      addr_d  = mem_addr;
      fill_we = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (flush) begin
               ready_d = 1'b0;
            end else if (fetch_able) begin
               if (hit) begin
                  ready_d = 1'b1;
                  out_d   = data_mem[pc_idx];
               end else begin
                  state_d = MISS;
                  req_d   = 1'b1;
                  addr_d  = {fetch_pc[ADDR_W-1:2], 2'b00};
               end
            end
         end
         MISS: begin
            if (mem_done) begin
               fill_we = 1'b1;
               req_d   = 1'b0;
               state_d = IDLE;
               if (!flush) begin
                  ready_d = 1'b1;
                  out_d   = mem_data;
               end
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (mem_done) begin
               fill_we = 1'b1;
               req_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         valid_q   <= '0;
         ins_ready <= 1'b0;
         ins_out   <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
      end else if (rdy_in) begin
         state_q   <= state_d;
         ins_ready <= ready_d;
         ins_out   <= out_d;
         mem_req   <= req_d;
         mem_addr  <= addr_d;
         if (fill_we) begin
            valid_q[fill_idx] <= 1'b1;
         end
      end
   end

   // NOTE: tag/data arrays carry no reset; the cleared valid bits already make their contents unobservable.
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && fill_we) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mem_data;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios with fixed expectations, then
// randomized traffic checked every cycle against a line-table/outstanding-request model.
module tb_icache;

   localparam int INDEX_BITS = 6;
   localparam int ADDR_W     = 32;
   localparam int LINES      = 1 << INDEX_BITS;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic              rdy_in;
   logic              fetch_able;
   logic [ADDR_W-1:0] fetch_pc;
   logic              flush;
   logic [31:0]       ins_out;
   logic              ins_ready;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;
   logic              mem_done;

   icache #(.INDEX_BITS(INDEX_BITS), .ADDR_W(ADDR_W)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .fetch_able(fetch_able),
      .fetch_pc  (fetch_pc),
      .flush     (flush),
      .ins_out   (ins_out),
      .ins_ready (ins_ready),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_done  (mem_done)
   );

   always #5 clk_in = ~clk_in;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Model: each line remembers the full word address it holds; a fill is one outstanding
   // request that is either wanted or, after a flush, dropped on arrival.
   bit          m_valid [LINES];
   logic [31:0] m_word  [LINES];
   logic [31:0] m_data  [LINES];
   bit          m_pending;
   bit          m_drop;
   logic [31:0] m_pend_addr;
   logic        exp_ready;
   logic [31:0] exp_out;
   logic        exp_req;
   logic [31:0] exp_addr;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic model_step();
      int idx;
      if (rst_in) begin
         for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
         m_pending = 1'b0;
         m_drop    = 1'b0;
         exp_ready = 1'b0;
         exp_out   = '0;
         exp_req   = 1'b0;
         exp_addr  = '0;
      end else if (rdy_in) begin
         if (m_pending) begin
            exp_ready = 1'b0;
            if (mem_done) begin
               idx          = int'((m_pend_addr >> 2) % LINES);
               m_valid[idx] = 1'b1;
               m_word[idx]  = m_pend_addr >> 2;
               m_data[idx]  = mem_data;
               m_pending    = 1'b0;
               exp_req      = 1'b0;
               if (!m_drop && !flush) begin
                  exp_ready = 1'b1;
                  exp_out   = mem_data;
               end
            end else if (flush) begin
               m_drop = 1'b1;
            end
         end else if (flush) begin
            exp_ready = 1'b0;
         end else if (fetch_able) begin
            idx = int'((fetch_pc >> 2) % LINES);
            if (m_valid[idx] && m_word[idx] == (fetch_pc >> 2)) begin
               exp_ready = 1'b1;
               exp_out   = m_data[idx];
            end else begin
               m_pending   = 1'b1;
               m_drop      = 1'b0;
               m_pend_addr = fetch_pc & 32'hFFFF_FFFC;
               exp_req     = 1'b1;
               exp_addr    = fetch_pc & 32'hFFFF_FFFC;
               exp_ready   = 1'b0;
            end
         end else begin
            exp_ready = 1'b0;
         end
      end
   endtask

   // One clock: advance the model on the edge, then compare just after it.
   task automatic cyc();
      @(posedge clk_in);
      model_step();
      #1;
      check("model_ins_ready", {31'b0, ins_ready}, {31'b0, exp_ready});
      check("model_mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      if (exp_ready) check("model_ins_out", ins_out, exp_out);
      if (exp_req) check("model_mem_addr", mem_addr, exp_addr);
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; fetch_able = 1'b0; fetch_pc = '0;
      flush = 1'b0; mem_data = '0; mem_done = 1'b0;

      // Reset state
      cyc();
      check("rst_ins_ready", {31'b0, ins_ready}, 32'd0);
      check("rst_ins_out", ins_out, 32'd0);
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);

      // Cold miss and fill forwarding
      rst_in = 1'b0; fetch_able = 1'b1; fetch_pc = 32'h4;
      cyc();
      check("cold_mem_req", {31'b0, mem_req}, 32'd1);
      check("cold_mem_addr", mem_addr, 32'h4);
      check("cold_ins_ready", {31'b0, ins_ready}, 32'd0);
      fetch_pc = 32'h20;
      cyc();
      check("miss_hold_addr", mem_addr, 32'h4);
      fetch_pc = 32'h4; mem_done = 1'b1; mem_data = 32'h0010_0093;
      cyc();
      check("fill_ins_ready", {31'b0, ins_ready}, 32'd1);
      check("fill_ins_out", ins_out, 32'h0010_0093);
      check("fill_mem_req", {31'b0, mem_req}, 32'd0);
      mem_done = 1'b0;
      cyc();
      check("hold_hit_ready", {31'b0, ins_ready}, 32'd1);

      // Hit after refetch
      fetch_able = 1'b0;
      cyc();
      check("idle_drop_ready", {31'b0, ins_ready}, 32'd0);
      fetch_able = 1'b1;
      cyc();
      check("hit_ins_ready", {31'b0, ins_ready}, 32'd1);
      check("hit_ins_out", ins_out, 32'h0010_0093);
      check("hit_mem_req", {31'b0, mem_req}, 32'd0);

      // Conflict on index 1
      fetch_pc = 32'h104;
      cyc();
      check("conf_mem_req", {31'b0, mem_req}, 32'd1);
      check("conf_mem_addr", mem_addr, 32'h104);
      mem_done = 1'b1; mem_data = 32'hAAAA_0001;
      cyc();
      check("conf_fill_out", ins_out, 32'hAAAA_0001);
      mem_done = 1'b0; fetch_pc = 32'h4;
      cyc();
      check("conf_remiss_req", {31'b0, mem_req}, 32'd1);
      check("conf_remiss_addr", mem_addr, 32'h4);
      mem_done = 1'b1; mem_data = 32'hBBBB_0002;
      cyc();
      check("conf_refill_out", ins_out, 32'hBBBB_0002);
      mem_done = 1'b0;

      // Flush mid-miss, drained fill still installs the line
      fetch_pc = 32'h8;
      cyc();
      check("drain_mem_addr", mem_addr, 32'h8);
      flush = 1'b1;
      cyc();
      check("drain_req_held", {31'b0, mem_req}, 32'd1);
      check("drain_no_ready", {31'b0, ins_ready}, 32'd0);
      flush = 1'b0;
      cyc();
      mem_done = 1'b1; mem_data = 32'hCCCC_0003;
      cyc();
      check("drain_done_ready", {31'b0, ins_ready}, 32'd0);
      check("drain_done_req", {31'b0, mem_req}, 32'd0);
      mem_done = 1'b0;
      cyc();
      check("drain_rehit_ready", {31'b0, ins_ready}, 32'd1);
      check("drain_rehit_out", ins_out, 32'hCCCC_0003);
      check("drain_rehit_req", {31'b0, mem_req}, 32'd0);

      // Stall during MISS; a mem_done under stall is lost
      fetch_pc = 32'hC;
      cyc();
      rdy_in = 1'b0; mem_done = 1'b1; mem_data = 32'hDEAD_0000;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("stall_mem_req", {31'b0, mem_req}, 32'd1);
         check("stall_mem_addr", mem_addr, 32'hC);
         check("stall_ins_ready", {31'b0, ins_ready}, 32'd0);
         mem_done = 1'b0;
      end
      rdy_in = 1'b1;
      cyc();
      check("stall_resume_req", {31'b0, mem_req}, 32'd1);
      mem_done = 1'b1; mem_data = 32'hDDDD_0004;
      cyc();
      check("stall_fill_out", ins_out, 32'hDDDD_0004);
      mem_done = 1'b0;

      // Flush in IDLE suppresses a hit
      fetch_pc = 32'h4;
      cyc();
      check("pre_flush_out", ins_out, 32'hBBBB_0002);
      flush = 1'b1;
      cyc();
      check("idle_flush_ready", {31'b0, ins_ready}, 32'd0);
      flush = 1'b0;
      cyc();
      check("post_flush_ready", {31'b0, ins_ready}, 32'd1);

      // Flush together with mem_done
      fetch_pc = 32'h10;
      cyc();
      flush = 1'b1; mem_done = 1'b1; mem_data = 32'hEEEE_0005;
      cyc();
      check("flush_done_ready", {31'b0, ins_ready}, 32'd0);
      check("flush_done_req", {31'b0, mem_req}, 32'd0);
      flush = 1'b0; mem_done = 1'b0;
      cyc();
      check("flush_done_hit", ins_out, 32'hEEEE_0005);

      // Spurious mem_done in IDLE
      mem_done = 1'b1; mem_data = 32'h1234_5678;
      cyc();
      check("spurious_out", ins_out, 32'hEEEE_0005);
      check("spurious_req", {31'b0, mem_req}, 32'd0);
      mem_done = 1'b0;

      // Reset mid-miss
      fetch_pc = 32'h14;
      cyc();
      rst_in = 1'b1;
      cyc();
      check("rst_miss_req", {31'b0, mem_req}, 32'd0);
      rst_in = 1'b0; fetch_able = 1'b0; mem_done = 1'b1; mem_data = 32'h0000_0055;
      cyc();
      check("rst_late_done", {31'b0, ins_ready}, 32'd0);
      mem_done = 1'b0; fetch_able = 1'b1; fetch_pc = 32'h4;
      cyc();
      check("rst_remiss_req", {31'b0, mem_req}, 32'd1);
      check("rst_remiss_addr", mem_addr, 32'h4);
      mem_done = 1'b1; mem_data = 32'h0010_0093;
      cyc();
      mem_done = 1'b0;

      // Randomized traffic over a few conflicting tags and indices
      for (int n = 0; n < 3000; n++) begin
         rst_in     = ($urandom_range(0, 199) == 0);
         rdy_in     = ($urandom_range(0, 9) != 0);
         flush      = ($urandom_range(0, 9) == 0);
         fetch_able = ($urandom_range(0, 4) != 0);
         fetch_pc   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2)
                      | 32'($urandom_range(0, 3));
         mem_data   = $urandom;
         mem_done   = m_pending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
